// File: rtl/cpu_mem_responder.sv
// Word-addressed memory serving independent instruction and data channels with fixed
// response latencies, byte-lane stores and a full-word host preload port.
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int INST_LAT   = 2,
  parameter int DATA_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ready,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ready,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  input  logic                  MemRead,
  output logic                  Mem_Req_Ready,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ready,
  input  logic                  host_wen,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic                  proto_err,
  output logic [31:0]           inst_cnt,
  output logic [31:0]           load_cnt,
  output logic [31:0]           store_cnt
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] I_LAT = 4'(INST_LAT);
  localparam logic [3:0] D_LAT = 4'(DATA_LAT);

  localparam logic [1:0] I_IDLE  = 2'd0;
  localparam logic [1:0] I_WAIT  = 2'd1;
  localparam logic [1:0] I_RESP  = 2'd2;

  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_RWAIT = 2'd1;
  localparam logic [1:0] D_WWAIT = 2'd2;
  localparam logic [1:0] D_RESP  = 2'd3;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]  i_state_q, i_state_d;
  logic [3:0]  i_cnt_q, i_cnt_d;
  logic [31:0] instr_q, instr_d;
  logic        i_valid_q, i_valid_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  logic [1:0]  d_state_q, d_state_d;
  logic [3:0]  d_cnt_q, d_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  logic        proto_err_q, proto_err_d;

  logic [ADDR_WIDTH-1:0] pc_idx_s;
  logic [ADDR_WIDTH-1:0] d_idx_s;
  logic                  wr_en_s;
  logic                  unused_addr_s;

  assign pc_idx_s      = PC[ADDR_WIDTH+1:2];
  assign d_idx_s       = Address[ADDR_WIDTH+1:2];
  assign wr_en_s       = (d_state_q == D_IDLE) && MemWrite && !rst;
  assign unused_addr_s = ^{PC[31:ADDR_WIDTH+2], PC[1:0], Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Instruction channel: capture on acceptance, count down latency, hold until taken
  always_comb begin
    i_state_d  = i_state_q;
    i_cnt_d    = i_cnt_q;
    instr_d    = instr_q;
    i_valid_d  = i_valid_q;
    inst_cnt_d = inst_cnt_q;
    case (i_state_q)
      I_IDLE: begin
        if (Inst_Req_Valid) begin
          instr_d    = mem_q[pc_idx_s];
          inst_cnt_d = inst_cnt_q + 32'd1;
          if (I_LAT == 4'd0) begin
            i_state_d = I_RESP;
            i_valid_d = 1'b1;
          end else begin
            i_state_d = I_WAIT;
            i_cnt_d   = I_LAT;
          end
        end else begin
          i_state_d = I_IDLE;
        end
      end
      I_WAIT: begin
        i_cnt_d = i_cnt_q - 4'd1;
        if (i_cnt_q <= 4'd1) begin
          i_state_d = I_RESP;
          i_valid_d = 1'b1;
        end else begin
          i_state_d = I_WAIT;
        end
      end
      I_RESP: begin
        if (Inst_Ready) begin
          i_state_d = I_IDLE;
          i_valid_d = 1'b0;
        end else begin
          i_state_d = I_RESP;
        end
      end
      default: begin
        i_state_d = I_IDLE;
        i_valid_d = 1'b0;
      end
    endcase
  end

  // Data channel: a write wins over a simultaneous read, which is dropped and flagged
  always_comb begin
    d_state_d   = d_state_q;
    d_cnt_d     = d_cnt_q;
    rdata_d     = rdata_q;
    r_valid_d   = r_valid_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    proto_err_d = proto_err_q;
    case (d_state_q)
      D_IDLE: begin
        if (MemWrite) begin
          store_cnt_d = store_cnt_q + 32'd1;
          if (MemRead) begin
            proto_err_d = 1'b1;
          end else begin
            proto_err_d = proto_err_q;
          end
          if (D_LAT == 4'd0) begin
            d_state_d = D_IDLE;
          end else begin
            d_state_d = D_WWAIT;
            d_cnt_d   = D_LAT;
          end
        end else if (MemRead) begin
          rdata_d    = mem_q[d_idx_s];
          load_cnt_d = load_cnt_q + 32'd1;
          if (D_LAT == 4'd0) begin
            d_state_d = D_RESP;
            r_valid_d = 1'b1;
          end else begin
            d_state_d = D_RWAIT;
            d_cnt_d   = D_LAT;
          end
        end else begin
          d_state_d = D_IDLE;
        end
      end
      D_RWAIT: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (d_cnt_q <= 4'd1) begin
          d_state_d = D_RESP;
          r_valid_d = 1'b1;
        end else begin
          d_state_d = D_RWAIT;
        end
      end
      D_WWAIT: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (d_cnt_q <= 4'd1) begin
          d_state_d = D_IDLE;
        end else begin
          d_state_d = D_WWAIT;
        end
      end
      D_RESP: begin
        if (Read_data_Ready) begin
          d_state_d = D_IDLE;
          r_valid_d = 1'b0;
        end else begin
          d_state_d = D_RESP;
        end
      end
      default: begin
        d_state_d = D_IDLE;
        r_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      i_state_q   <= I_IDLE;
      i_cnt_q     <= 4'd0;
      instr_q     <= 32'd0;
      i_valid_q   <= 1'b0;
      inst_cnt_q  <= 32'd0;
      d_state_q   <= D_IDLE;
      d_cnt_q     <= 4'd0;
      rdata_q     <= 32'd0;
      r_valid_q   <= 1'b0;
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      i_state_q   <= i_state_d;
      i_cnt_q     <= i_cnt_d;
      instr_q     <= instr_d;
      i_valid_q   <= i_valid_d;
      inst_cnt_q  <= inst_cnt_d;
      d_state_q   <= d_state_d;
      d_cnt_q     <= d_cnt_d;
      rdata_q     <= rdata_d;
      r_valid_q   <= r_valid_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage is not reset; the host write is issued last so it overrides a same-word store
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && Write_strb[b]) begin
        mem_q[d_idx_s][8*b +: 8] <= Write_data[8*b +: 8];
      end
    end
    if (host_wen) begin
      mem_q[host_addr] <= host_wdata;
    end
  end

  assign Inst_Req_Ready  = (i_state_q == I_IDLE);
  assign Instruction     = instr_q;
  assign Inst_Valid      = i_valid_q;
  assign Mem_Req_Ready   = (d_state_q == D_IDLE);
  assign Read_data       = rdata_q;
  assign Read_data_Valid = r_valid_q;
  assign proto_err       = proto_err_q;
  assign inst_cnt        = inst_cnt_q;
  assign load_cnt        = load_cnt_q;
  assign store_cnt       = store_cnt_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses from a word-array model, a
// separate monitor pops and compares data and latency whenever a response is presented.
module tb_cpu_mem_responder;
  localparam int AW    = 10;
  localparam int IL    = 2;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk, rst;
  logic [31:0]   PC, Instruction, Address, Write_data, Read_data, host_wdata;
  logic          Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
  logic          MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
  logic [3:0]    Write_strb;
  logic          host_wen, proto_err;
  logic [AW-1:0] host_addr;
  logic [31:0]   inst_cnt, load_cnt, store_cnt;

  cpu_mem_responder #(.ADDR_WIDTH(AW), .INST_LAT(IL), .DATA_LAT(DL)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
    .proto_err(proto_err), .inst_cnt(inst_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t        inst_exp[$];
  exp_t        rd_exp[$];
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0, total = 0, bad = 0;
  bit          inst_busy, data_busy, m_proto;
  int          inst_free_cyc, data_free_cyc;
  logic [31:0] m_inst, m_load, m_store;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  function automatic bit inst_free();
    return !inst_busy && (cyc >= inst_free_cyc);
  endfunction

  function automatic bit data_free();
    return !data_busy && (cyc >= data_free_cyc);
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
  endfunction

  // Issue helpers: call order within one cycle is fetch, data, host (reads see old words)
  task automatic issue_fetch(input logic [31:0] pc);
    exp_t e;
    PC = pc;
    Inst_Req_Valid = 1'b1;
    e.data = ref_mem[widx(pc)];
    e.due  = cyc + 1 + IL;
    inst_exp.push_back(e);
    inst_busy = 1'b1;
    m_inst = m_inst + 32'd1;
  endtask

  task automatic issue_load(input logic [31:0] a);
    exp_t e;
    Address = a;
    MemRead = 1'b1;
    MemWrite = 1'b0;
    e.data = ref_mem[widx(a)];
    e.due  = cyc + 1 + DL;
    rd_exp.push_back(e);
    data_busy = 1'b1;
    m_load = m_load + 32'd1;
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb, input bit both);
    logic [31:0] mask;
    Address = a;
    MemWrite = 1'b1;
    MemRead = both;
    Write_data = wd;
    Write_strb = strb;
    mask = 32'd0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    ref_mem[widx(a)] = (ref_mem[widx(a)] & ~mask) | (wd & mask);
    data_free_cyc = cyc + 1 + DL;
    m_store = m_store + 32'd1;
    if (both) m_proto = 1'b1;
  endtask

  task automatic host_write(input int idx, input logic [31:0] d);
    host_wen = 1'b1;
    host_addr = AW'(idx);
    host_wdata = d;
    ref_mem[idx] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    Inst_Req_Valid = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    host_wen = 1'b0;
    @(negedge clk);
    #1;
    check("inst_req_ready", 32'(Inst_Req_Ready), 32'(inst_free()));
    check("mem_req_ready", 32'(Mem_Req_Ready), 32'(data_free()));
    check("inst_cnt", inst_cnt, m_inst);
    check("load_cnt", load_cnt, m_load);
    check("store_cnt", store_cnt, m_store);
    check("proto_err", 32'(proto_err), 32'(m_proto));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Inst_Req_Valid = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    host_wen = 1'b0;
    inst_exp.delete();
    rd_exp.delete();
    inst_busy = 1'b0;
    data_busy = 1'b0;
    inst_free_cyc = 0;
    data_free_cyc = 0;
    m_inst = 32'd0;
    m_load = 32'd0;
    m_store = 32'd0;
    m_proto = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_inst_req_ready", 32'(Inst_Req_Ready), 32'd1);
    check("rst_mem_req_ready", 32'(Mem_Req_Ready), 32'd1);
    check("rst_inst_valid", 32'(Inst_Valid), 32'd0);
    check("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
    check("rst_instruction", Instruction, 32'd0);
    check("rst_read_data", Read_data, 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_inst_cnt", inst_cnt, 32'd0);
    check("rst_load_cnt", load_cnt, 32'd0);
    check("rst_store_cnt", store_cnt, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    Inst_Ready = 1'b1;
    Read_data_Ready = 1'b1;
    while ((inst_exp.size() != 0 || rd_exp.size() != 0 || !data_free() || !inst_free()) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) fail_now("drain_timeout", "responses still outstanding after 100 cycles, required none");
  endtask

  // Monitor: runs after stimulus in each low phase, so ready inputs seen here apply to the next edge
  bit ip, rp;
  initial begin
    ip = 1'b0;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        ip = 1'b0;
        rp = 1'b0;
      end else begin
        if (Inst_Valid) begin
          if (inst_exp.size() == 0) begin
            fail_now("inst_unexpected", $sformatf("Inst_Valid=1 data %h, required no response", Instruction));
          end else begin
            check("instruction", Instruction, inst_exp[0].data);
            if (!ip) check("inst_latency", 32'(cyc), 32'(inst_exp[0].due));
            if (Inst_Ready) begin
              inst_exp.delete(0);
              inst_busy = 1'b0;
              inst_free_cyc = cyc + 1;
            end
          end
        end else if (inst_exp.size() != 0 && cyc > inst_exp[0].due) begin
          fail_now("inst_late", $sformatf("Inst_Valid=0, required 1 by cycle %0d", inst_exp[0].due));
          inst_exp.delete(0);
          inst_busy = 1'b0;
          inst_free_cyc = cyc + 1;
        end
        ip = Inst_Valid;

        if (Read_data_Valid) begin
          if (rd_exp.size() == 0) begin
            fail_now("rd_unexpected", $sformatf("Read_data_Valid=1 data %h, required no response", Read_data));
          end else begin
            check("read_data", Read_data, rd_exp[0].data);
            if (!rp) check("rd_latency", 32'(cyc), 32'(rd_exp[0].due));
            if (Read_data_Ready) begin
              rd_exp.delete(0);
              data_busy = 1'b0;
              data_free_cyc = cyc + 1;
            end
          end
        end else if (rd_exp.size() != 0 && cyc > rd_exp[0].due) begin
          fail_now("rd_late", $sformatf("Read_data_Valid=0, required 1 by cycle %0d", rd_exp[0].due));
          rd_exp.delete(0);
          data_busy = 1'b0;
          data_free_cyc = cyc + 1;
        end
        rp = Read_data_Valid;
      end
    end
  end

  initial begin
    PC = 32'd0; Address = 32'd0; Write_data = 32'd0; Write_strb = 4'd0;
    Inst_Ready = 1'b1; Read_data_Ready = 1'b1; host_addr = '0; host_wdata = 32'd0;
    do_reset();

    for (int i = 0; i < DEPTH; i++) begin
      host_write(i, $urandom);
      step();
    end

    // Fetch of a preloaded word
    host_write(4, 32'h0050_0093);
    step();
    issue_fetch(32'h0000_0010);
    step();
    drain();

    // Backpressure on the instruction response, with a store to the same word meanwhile
    Inst_Ready = 1'b0;
    issue_fetch(32'h0000_0010);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) issue_store(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
      step();
    end
    drain();

    // Byte-lane store followed by a load
    host_write(8, 32'h1122_3344);
    step();
    issue_store(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0);
    step();
    drain();
    issue_load(32'h0000_0020);
    step();
    drain();

    // Concurrent fetch and load, then fetch racing a store to the same word
    issue_fetch(32'h0000_0020);
    issue_load(32'h0000_0010);
    step();
    drain();
    issue_fetch(32'h0000_0040);
    issue_store(32'h0000_0040, 32'h1357_9BDF, 4'hF, 1'b0);
    step();
    drain();

    // Store and host write to the same word in one cycle
    issue_store(32'h0000_0044, 32'h0101_0101, 4'hF, 1'b0);
    host_write(17, 32'hCAFE_F00D);
    step();
    drain();
    issue_load(32'h0000_0044);
    step();
    drain();

    // Read and write together: write applies, no response, sticky error
    issue_store(32'h0000_0048, 32'h2468_ACE0, 4'hF, 1'b1);
    step();
    drain();
    issue_load(32'h0000_0048);
    step();
    drain();
    repeat (3) step();

    // Reset while a load waits; its response must never appear and memory survives
    issue_load(32'h0000_0048);
    step();
    step();
    do_reset();
    repeat (8) step();
    issue_load(32'h0000_0048);
    step();
    drain();

    for (int k = 0; k < 2000; k++) begin
      Inst_Ready = ($urandom_range(0, 3) != 0);
      Read_data_Ready = ($urandom_range(0, 3) != 0);
      if (inst_free() && $urandom_range(0, 1) == 1) issue_fetch(rand_addr());
      if (data_free()) begin
        case ($urandom_range(0, 2))
          0: issue_load(rand_addr());
          1: issue_store(rand_addr(), $urandom, 4'($urandom_range(0, 15)), 1'b0);
          default: ;
        endcase
      end
      if ($urandom_range(0, 7) == 0) host_write($urandom_range(0, 15), $urandom);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
